// File: rtl/ps2_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : ps2_pkg                                                      |
// | Brief   : Shared PS/2 types, command bytes and 25 MHz timing defaults. |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
package ps2_pkg;

  // Host-to-device transmitter states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } ps2_tx_state_e;

  // Common keyboard command bytes
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;

  // Timing defaults for a 25 MHz system clock
  localparam int PS2_INHIBIT_CYCLES_25M = 3000;    // 120 us
  localparam int PS2_START_TIMEOUT_25M  = 375000;  // 15 ms
  localparam int PS2_XFER_TIMEOUT_25M   = 50000;   // 2 ms
  localparam int PS2_FILTER_LEN_DEFAULT = 8;

  // PS/2 frames use odd parity over the data byte
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_host_tx_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : ps2_host_tx_if                                               |
// | Brief   : Byte request / status handshake of the PS/2 transmitter.     |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
interface ps2_host_tx_if;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;
  logic       TX_BUSY;
  logic       TX_DONE;
  logic       TX_ERR;

  modport master (
    output TX_DATA, TX_VALID,
    input  TX_READY, TX_BUSY, TX_DONE, TX_ERR
  );

  modport slave (
    input  TX_DATA, TX_VALID,
    output TX_READY, TX_BUSY, TX_DONE, TX_ERR
  );
endinterface
`default_nettype wire

// File: rtl/ps2_clk_filter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : ps2_clk_filter                                               |
// | Brief   : Pad synchronizers, PS2 clock debounce and falling-edge pulse.|
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic ps2_clk,
  input  wire logic ps2_data,
  output logic      clk_level,
  output logic      clk_fall,
  output logic      data_sync
);

  localparam int             c_fw   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [c_fw-1:0] c_last = c_fw'(FILTER_LEN - 1);

  logic [1:0]      r_clk_sync;
  logic [1:0]      r_data_sync;
  logic            r_level;
  logic            r_fall;
  logic [c_fw-1:0] r_cnt;

  // Two-flop synchronizers; an idle bus floats high
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], ps2_clk};
      r_data_sync <= {r_data_sync[0], ps2_data};
    end
  end

  // Accept a new clock level only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= 1'b1;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_fall <= 1'b0;
      if (r_clk_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_last) begin
        r_level <= r_clk_sync[1];
        r_fall  <= r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign clk_level = r_level;
  assign clk_fall  = r_fall;
  assign data_sync = r_data_sync[1];

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : ps2_host_tx                                                  |
// | Brief   : PS/2 host-to-device command byte transmitter (open drain).   |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES_25M,
  parameter int START_TIMEOUT  = PS2_START_TIMEOUT_25M,
  parameter int XFER_TIMEOUT   = PS2_XFER_TIMEOUT_25M,
  parameter int FILTER_LEN     = PS2_FILTER_LEN_DEFAULT
) (
  input  wire logic     CLK_25MHZ,
  input  wire logic     RESET,
  input  wire logic     PS2_CLK,
  input  wire logic     PS2_DATA,
  output logic          PS2_CLK_OE,
  output logic          PS2_DATA_OE,
  ps2_host_tx_if.slave  tx
);

  // One shared counter serves inhibit, start timeout and transfer timeout,
  // so it must hold the largest of the three limits.
  localparam int c_cnt_max = (START_TIMEOUT > XFER_TIMEOUT)
                           ? ((START_TIMEOUT > INHIBIT_CYCLES) ? START_TIMEOUT : INHIBIT_CYCLES)
                           : ((XFER_TIMEOUT > INHIBIT_CYCLES) ? XFER_TIMEOUT : INHIBIT_CYCLES);
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

  ps2_tx_state_e      r_state, w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [3:0]         r_bit_idx, w_bit_idx_nxt;
  logic [7:0]         r_byte;
  logic               r_par;
  logic               r_clk_oe, w_clk_oe_nxt;
  logic               r_data_oe, w_data_oe_nxt;
  logic               r_done, w_done_nxt;
  logic               r_err, w_err_nxt;
  logic               w_clk_level, w_clk_fall, w_data_sync;
  logic [9:0]         w_frame;

  ps2_clk_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk       (CLK_25MHZ),
    .rst       (RESET),
    .ps2_clk   (PS2_CLK),
    .ps2_data  (PS2_DATA),
    .clk_level (w_clk_level),
    .clk_fall  (w_clk_fall),
    .data_sync (w_data_sync)
  );

  // Bits in send order: data LSB-first, parity, then stop (released line)
  assign w_frame   = {1'b1, r_par, r_byte};
  assign w_cnt_inc = (r_cnt == {c_cnt_w{1'b1}}) ? r_cnt : r_cnt + 1'b1;

  // State, counter and registered line/status outputs
  always_ff @(posedge CLK_25MHZ) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_clk_oe  <= w_clk_oe_nxt;
      r_data_oe <= w_data_oe_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Capture the command byte and its parity at the accept handshake
  always_ff @(posedge CLK_25MHZ) begin
    if (RESET) begin
      r_byte <= '0;
      r_par  <= 1'b0;
    end else if (r_state == ST_IDLE && tx.TX_VALID) begin
      r_byte <= tx.TX_DATA;
      r_par  <= odd_parity(tx.TX_DATA);
    end
  end

  // Next-state logic; timeouts are tested before edges so they take priority
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = w_cnt_inc;
    w_bit_idx_nxt = r_bit_idx;
    w_clk_oe_nxt  = r_clk_oe;
    w_data_oe_nxt = r_data_oe;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_cnt_nxt     = '0;
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
        if (tx.TX_VALID) begin
          w_state_nxt  = ST_INHIBIT;
          w_clk_oe_nxt = 1'b1;
        end
      end
      ST_INHIBIT: begin
        if (w_cnt_inc == c_cnt_w'(INHIBIT_CYCLES)) begin
          w_state_nxt   = ST_REQ;
          w_clk_oe_nxt  = 1'b0;
          w_data_oe_nxt = 1'b1;
          w_cnt_nxt     = '0;
        end
      end
      ST_REQ: begin
        if (w_cnt_inc == c_cnt_w'(START_TIMEOUT)) begin
          w_state_nxt   = ST_IDLE;
          w_err_nxt     = 1'b1;
          w_clk_oe_nxt  = 1'b0;
          w_data_oe_nxt = 1'b0;
        end else if (w_clk_fall) begin
          w_state_nxt   = ST_SHIFT;
          w_data_oe_nxt = ~w_frame[0];
          w_bit_idx_nxt = 4'd1;
          w_cnt_nxt     = '0;
        end
      end
      ST_SHIFT: begin
        if (w_cnt_inc == c_cnt_w'(XFER_TIMEOUT)) begin
          w_state_nxt   = ST_IDLE;
          w_err_nxt     = 1'b1;
          w_clk_oe_nxt  = 1'b0;
          w_data_oe_nxt = 1'b0;
        end else if (w_clk_fall) begin
          w_data_oe_nxt = ~w_frame[r_bit_idx];
          if (r_bit_idx == 4'd9) begin
            w_state_nxt = ST_ACK;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 4'd1;
          end
        end
      end
      ST_ACK: begin
        if (w_cnt_inc == c_cnt_w'(XFER_TIMEOUT) || (w_clk_fall && w_data_sync)) begin
          w_state_nxt   = ST_IDLE;
          w_err_nxt     = 1'b1;
          w_clk_oe_nxt  = 1'b0;
          w_data_oe_nxt = 1'b0;
        end else if (w_clk_fall) begin
          w_state_nxt = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (w_cnt_inc == c_cnt_w'(XFER_TIMEOUT)) begin
          w_state_nxt   = ST_IDLE;
          w_err_nxt     = 1'b1;
          w_clk_oe_nxt  = 1'b0;
          w_data_oe_nxt = 1'b0;
        end else if (w_clk_level && w_data_sync) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
      end
    endcase
  end

  assign PS2_CLK_OE  = r_clk_oe;
  assign PS2_DATA_OE = r_data_oe;
  assign tx.TX_READY = (r_state == ST_IDLE);
  assign tx.TX_BUSY  = (r_state != ST_IDLE);
  assign tx.TX_DONE  = r_done;
  assign tx.TX_ERR   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | Module  : tb_ps2_host_tx                                               |
// | Brief   : Self-checking bench with a PS/2 device model and scoreboard. |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INHIBIT  = 3000;
  localparam int START_TO = 4000;
  localparam int XFER_TO  = 3000;
  localparam int FLEN     = 8;
  localparam int HALF     = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic glitch_low = 1'b0;
  logic clk_oe, data_oe;
  logic ps2_clk_pad, ps2_data_pad;

  ps2_host_tx_if tx_if ();

  // Open-drain bus: anyone pulling low wins
  assign ps2_clk_pad  = dev_clk & ~clk_oe & ~glitch_low;
  assign ps2_data_pad = dev_data & ~data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INHIBIT),
    .START_TIMEOUT  (START_TO),
    .XFER_TIMEOUT   (XFER_TO),
    .FILTER_LEN     (FLEN)
  ) dut (
    .CLK_25MHZ   (clk),
    .RESET       (rst),
    .PS2_CLK     (ps2_clk_pad),
    .PS2_DATA    (ps2_data_pad),
    .PS2_CLK_OE  (clk_oe),
    .PS2_DATA_OE (data_oe),
    .tx          (tx_if)
  );

  always #20 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard: line bits the device should sample, and transfer outcomes (1 done, 2 err)
  logic exp_bits[$];
  int   exp_out[$];

  // Pulse / line monitor, sampled mid-cycle
  int   cyc = 0;
  int   done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int   err_cyc = 0, oe_fall_cyc = 0;
  logic [1:0] oe_at_err = 2'b00, oe_after_err = 2'b00;
  logic ready_at_err = 1'b0, ready_at_done = 1'b0;
  logic prev_err = 1'b0, prev_clk_oe = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_if.TX_DONE) begin
      done_cnt      <= done_cnt + 1;
      ready_at_done <= tx_if.TX_READY;
    end
    if (tx_if.TX_ERR) begin
      err_cnt      <= err_cnt + 1;
      err_cyc      <= cyc;
      oe_at_err    <= {clk_oe, data_oe};
      ready_at_err <= tx_if.TX_READY;
    end
    if (prev_err) oe_after_err <= {clk_oe, data_oe};
    if (tx_if.TX_DONE && tx_if.TX_ERR) both_cnt <= both_cnt + 1;
    if (prev_clk_oe && !clk_oe) oe_fall_cyc <= cyc;
    prev_err    <= tx_if.TX_ERR;
    prev_clk_oe <= clk_oe;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic par_of(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2 == 0);
  endfunction

  // Issue a request; optionally push the expected frame and outcome
  task automatic send_req(input logic [7:0] d, input bit push_bits, input int outcome);
    int n = 0;
    while (!tx_if.TX_READY && n < 1000) begin n++; tick(); end
    if (!tx_if.TX_READY) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_wait: TX_READY stayed 0 before sending %h", d);
    end
    if (push_bits) begin
      for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
      exp_bits.push_back(par_of(d));
      exp_bits.push_back(1'b1);
    end
    if (outcome != 0) exp_out.push_back(outcome);
    tx_if.TX_DATA  = d;
    tx_if.TX_VALID = 1'b1;
    tick();
    tx_if.TX_VALID = 1'b0;
    tx_if.TX_DATA  = 8'($urandom);
    n_cmp++;
    if (clk_oe !== 1'b1) begin n_bad++; $display("FAIL accept_clk_oe: got %b want 1", clk_oe); end
    n_cmp++;
    if (tx_if.TX_BUSY !== 1'b1) begin n_bad++; $display("FAIL accept_busy: got %b want 1", tx_if.TX_BUSY); end
  endtask

  // Measure the inhibit window and check the start bit when the clock is released
  task automatic wait_release();
    int n = 0;
    while (clk_oe === 1'b1 && n < INHIBIT + 100) begin n++; tick(); end
    n_cmp++;
    if (n !== INHIBIT) begin n_bad++; $display("FAIL inhibit_len: got %0d cycles want %0d", n, INHIBIT); end
    n_cmp++;
    if (ps2_data_pad !== 1'b0) begin n_bad++; $display("FAIL start_bit: data line %b want 0", ps2_data_pad); end
  endtask

  // Device model: generate nclk clock pulses, sampling data on each rising edge
  task automatic run_clocks(input int nclk, input bit ack, input bit glitch_en);
    logic got_b, exp_b;
    repeat (50) tick();
    for (int i = 1; i <= nclk; i++) begin
      if (i == 11 && ack) dev_data = 1'b0;
      dev_clk = 1'b0;
      repeat (HALF) tick();
      dev_clk = 1'b1;
      if (i == 11) dev_data = 1'b1;
      if (i <= 10) begin
        got_b = ps2_data_pad;
        n_cmp++;
        if (exp_bits.size() == 0) begin
          n_bad++; $display("FAIL bit%0d: scoreboard empty, line=%b", i, got_b);
        end else begin
          exp_b = exp_bits.pop_front();
          if (got_b !== exp_b) begin n_bad++; $display("FAIL bit%0d: line %b want %b", i, got_b, exp_b); end
        end
      end
      for (int k = 0; k < HALF; k++) begin
        if (glitch_en && k == 15) glitch_low = 1'b1;
        if (glitch_en && k == 18) glitch_low = 1'b0;
        tick();
      end
    end
  endtask

  // Wait for exactly one DONE/ERR pulse since the snapshot and check it against the scoreboard
  task automatic wait_outcome(input int d0, input int e0, input int limit);
    int n = 0;
    int got, want;
    while (done_cnt == d0 && err_cnt == e0 && n < limit) begin n++; tick(); end
    repeat (3) tick();
    got  = ((done_cnt != d0) ? 1 : 0) + ((err_cnt != e0) ? 2 : 0);
    want = (exp_out.size() != 0) ? exp_out.pop_front() : -1;
    n_cmp++;
    if (got !== want) begin n_bad++; $display("FAIL outcome: got %0d want %0d (1=done 2=err)", got, want); end
    n_cmp++;
    if ((done_cnt - d0) + (err_cnt - e0) !== 1) begin
      n_bad++; $display("FAIL pulse_count: got %0d pulses want 1", (done_cnt - d0) + (err_cnt - e0));
    end
    if (want == 2) begin
      n_cmp++;
      if (oe_at_err !== 2'b00 || oe_after_err !== 2'b00) begin
        n_bad++; $display("FAIL err_release: oe %b then %b want 00", oe_at_err, oe_after_err);
      end
      n_cmp++;
      if (ready_at_err !== 1'b1) begin n_bad++; $display("FAIL err_ready: got %b want 1", ready_at_err); end
    end else if (want == 1) begin
      n_cmp++;
      if (ready_at_done !== 1'b1) begin n_bad++; $display("FAIL done_ready: got %b want 1", ready_at_done); end
    end
    n_cmp++;
    if (tx_if.TX_READY !== 1'b1) begin n_bad++; $display("FAIL post_ready: got %b want 1", tx_if.TX_READY); end
  endtask

  task automatic full_xfer(input logic [7:0] d, input bit ack, input bit glitch_en);
    int d0, e0;
    send_req(d, 1'b1, ack ? 1 : 2);
    wait_release();
    d0 = done_cnt; e0 = err_cnt;
    run_clocks(11, ack, glitch_en);
    wait_outcome(d0, e0, 2000);
    repeat (20) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({clk_oe, data_oe} !== 2'b00) begin n_bad++; $display("FAIL reset_oe: got %b want 00", {clk_oe, data_oe}); end
    n_cmp++;
    if ({tx_if.TX_READY, tx_if.TX_BUSY} !== 2'b10) begin
      n_bad++; $display("FAIL reset_ready_busy: got %b want 10", {tx_if.TX_READY, tx_if.TX_BUSY});
    end
    n_cmp++;
    if ({tx_if.TX_DONE, tx_if.TX_ERR} !== 2'b00) begin
      n_bad++; $display("FAIL reset_pulses: got %b want 00", {tx_if.TX_DONE, tx_if.TX_ERR});
    end
    rst = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_set_leds();
    full_xfer(PS2_CMD_SET_LEDS, 1'b1, 1'b0);
  endtask

  // Also pokes TX_VALID while busy: must be ignored, frame unchanged
  task automatic test_enable_busy_ignore();
    int d0, e0;
    send_req(PS2_CMD_ENABLE, 1'b1, 1);
    wait_release();
    d0 = done_cnt; e0 = err_cnt;
    tx_if.TX_DATA  = 8'h55;
    tx_if.TX_VALID = 1'b1;
    repeat (2) tick();
    tx_if.TX_VALID = 1'b0;
    run_clocks(11, 1'b1, 1'b0);
    wait_outcome(d0, e0, 2000);
    repeat (20) tick();
    n_cmp++;
    if (clk_oe !== 1'b0) begin n_bad++; $display("FAIL busy_ignore: clk_oe %b want 0 (request queued)", clk_oe); end
  endtask

  task automatic test_no_ack();
    full_xfer(8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_start_timeout();
    int d0, e0;
    send_req(PS2_CMD_RESET, 1'b0, 2);
    wait_release();
    d0 = done_cnt; e0 = err_cnt;
    wait_outcome(d0, e0, START_TO + 100);
    n_cmp++;
    if (err_cyc - oe_fall_cyc !== START_TO) begin
      n_bad++; $display("FAIL start_timeout: err after %0d cycles want %0d", err_cyc - oe_fall_cyc, START_TO);
    end
    repeat (20) tick();
  endtask

  task automatic test_reset_mid();
    int d0, e0;
    send_req(PS2_CMD_RESET, 1'b1, 0);
    wait_release();
    run_clocks(4, 1'b0, 1'b0);
    d0 = done_cnt; e0 = err_cnt;
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({clk_oe, data_oe} !== 2'b00) begin n_bad++; $display("FAIL midreset_oe: got %b want 00", {clk_oe, data_oe}); end
    n_cmp++;
    if (tx_if.TX_READY !== 1'b1) begin n_bad++; $display("FAIL midreset_ready: got %b want 1", tx_if.TX_READY); end
    rst = 1'b0;
    repeat (10) tick();
    n_cmp++;
    if (done_cnt != d0 || err_cnt != e0) begin
      n_bad++; $display("FAIL midreset_pulse: done+%0d err+%0d want none", done_cnt - d0, err_cnt - e0);
    end
    exp_bits.delete();
    full_xfer(PS2_CMD_ENABLE, 1'b1, 1'b0);
  endtask

  task automatic test_glitch();
    full_xfer(8'hA6, 1'b1, 1'b1);
  endtask

  task automatic test_exclusive_pulses();
    n_cmp++;
    if (both_cnt !== 0) begin n_bad++; $display("FAIL done_err_overlap: got %0d cycles want 0", both_cnt); end
  endtask

  initial begin
    tx_if.TX_DATA  = 8'h00;
    tx_if.TX_VALID = 1'b0;
    test_reset();
    test_set_leds();
    test_enable_busy_ignore();
    test_no_ack();
    test_start_timeout();
    test_reset_mid();
    test_glitch();
    test_exclusive_pulses();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
